output_memory: RTL and testbench

//   Result-side buffer for the 4-row systolic array: mirrors the input memory.

---
 rtl/output_memory_if.sv | 30 +++
 rtl/output_memory.sv | 106 ++++++++++
 tb/tb_output_memory.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/output_memory_if.sv
// Bus bundle for output_memory: capture lanes, host read port and status flags.
interface output_memory_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 10
);
  logic              start;
  logic [8:0]        len;
  logic [3:0]        in_valid;
  logic [DATA_W-1:0] in0;
  logic [DATA_W-1:0] in1;
  logic [DATA_W-1:0] in2;
  logic [DATA_W-1:0] in3;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic              overflow;

  modport master (
    output start, len, in_valid, in0, in1, in2, in3, rd_en, rd_addr,
    input  rd_data, rd_valid, busy, done, overflow
  );

  modport slave (
    input  start, len, in_valid, in0, in1, in2, in3, rd_en, rd_addr,
    output rd_data, rd_valid, busy, done, overflow
  );
endinterface

// File: rtl/output_memory.sv
// Result-side buffer for the 4-row systolic array. Each row lane has its own
// write pointer so skewed result streams land deskewed in columns; the host
// reads back by flat address {col, row}.
module output_memory #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 10
) (
  input logic             clk,
  input logic             rst,
  output_memory_if.slave  bus
);

  localparam int unsigned ColW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

  state_e            state_q, state_d;
  logic [8:0]        len_q, len_d;
  logic [8:0]        wp_q [4];
  logic [8:0]        wp_d [4];
  logic              overflow_q, overflow_d;
  logic [3:0]        we;
  logic              all_full;
  logic [DATA_W-1:0] lane_data [4];
  logic [DATA_W-1:0] mem [4][DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  assign lane_data[0] = bus.in0;
  assign lane_data[1] = bus.in1;
  assign lane_data[2] = bus.in2;
  assign lane_data[3] = bus.in3;

  // Next-state: start overrides everything; capture advances each lane independently.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wp_d       = wp_q;
    overflow_d = overflow_q;
    we         = '0;
    all_full   = 1'b1;
    if (bus.start) begin
      len_d      = bus.len;
      overflow_d = 1'b0;
      for (int r = 0; r < 4; r++) wp_d[r] = '0;
      state_d = (bus.len == '0) ? StDone : StCapture;
    end else if (state_q == StCapture) begin
      for (int r = 0; r < 4; r++) begin
        if (bus.in_valid[r]) begin
          if (wp_q[r] < len_q) begin
            we[r]   = 1'b1;
            wp_d[r] = wp_q[r] + 9'd1;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
      // Finish as soon as the last lane's final write lands.
      for (int r = 0; r < 4; r++) begin
        if (wp_d[r] != len_q) all_full = 1'b0;
      end
      if (all_full) state_d = StDone;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      overflow_q <= 1'b0;
      for (int r = 0; r < 4; r++) wp_q[r] <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      overflow_q <= overflow_d;
      for (int r = 0; r < 4; r++) wp_q[r] <= wp_d[r];
    end
  end

  // Lane storage; not cleared by reset so partial captures stay readable.
  always_ff @(posedge clk) begin
    for (int r = 0; r < 4; r++) begin
      if (we[r] && !rst) mem[r][wp_q[r][ColW-1:0]] <= lane_data[r];
    end
  end

  // Registered read port; a same-cycle write is seen only by later reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= mem[bus.rd_addr[1:0]][bus.rd_addr[ADDR_W-1:2]];
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = (state_q == StCapture);
  assign bus.done     = (state_q == StDone);
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_output_memory.sv
// Self-checking bench for output_memory: directed scenarios plus random traffic
// against a per-cycle reference of the capture/read rules.
module tb_output_memory;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  output_memory #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference: 0 idle, 1 capture, 2 done
  int          m_st = 0;
  int          m_len = 0;
  int          m_wp [4];
  bit          m_ovf = 1'b0;
  bit          m_rdv = 1'b0;
  logic [15:0] m_rdd = '0;
  bit          m_rdd_known = 1'b0;
  logic [15:0] m_mem [4][DEPTH];
  bit          m_wr [4][DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit s, input logic [8:0] ln, input logic [3:0] v,
                      input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2,
                      input logic [15:0] d3, input bit re, input logic [9:0] ra);
    logic [15:0] d [4];
    int row, col;
    bit fin;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    rst = r; bus.start = s; bus.len = ln; bus.in_valid = v;
    bus.in0 = d0; bus.in1 = d1; bus.in2 = d2; bus.in3 = d3;
    bus.rd_en = re; bus.rd_addr = ra;
    @(posedge clk);
    if (r) begin
      m_st = 0; m_ovf = 1'b0; m_rdv = 1'b0; m_rdd = '0; m_rdd_known = 1'b1;
      for (int l = 0; l < 4; l++) m_wp[l] = 0;
    end else begin
      m_rdv = re;
      if (re) begin
        row = int'(ra[1:0]);
        col = int'(ra[9:2]);
        m_rdd_known = m_wr[row][col];
        m_rdd = m_mem[row][col];
      end
      if (s) begin
        m_len = int'(ln);
        m_ovf = 1'b0;
        for (int l = 0; l < 4; l++) m_wp[l] = 0;
        m_st = (ln == 0) ? 2 : 1;
      end else if (m_st == 1) begin
        for (int l = 0; l < 4; l++) begin
          if (v[l]) begin
            if (m_wp[l] < m_len) begin
              m_mem[l][m_wp[l]] = d[l];
              m_wr[l][m_wp[l]] = 1'b1;
              m_wp[l]++;
            end else begin
              m_ovf = 1'b1;
            end
          end
        end
        fin = 1'b1;
        for (int l = 0; l < 4; l++) if (m_wp[l] != m_len) fin = 1'b0;
        if (fin) m_st = 2;
      end
    end
    #1;
    check("busy", bus.busy, m_st == 1);
    check("done", bus.done, m_st == 2);
    check("overflow", bus.overflow, m_ovf);
    check("rd_valid", bus.rd_valid, m_rdv);
    if (m_rdd_known) check("rd_data", bus.rd_data, m_rdd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input logic [9:0] a);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, a);
  endtask

  initial begin
    logic [15:0] dd [4];
    logic [3:0]  v;
    logic [9:0]  a;
    for (int l = 0; l < 4; l++) m_wp[l] = 0;

    // Reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_rdv", bus.rd_valid, 0);
    check("rst_rdd", bus.rd_data, 0);
    idle(2);

    // Skewed capture, len=3, row r valid on cycles r..r+2
    step(0, 1, 9'd3, 0, 0, 0, 0, 0, 0, 0);
    check("skew_busy0", bus.busy, 1);
    for (int c = 0; c < 6; c++) begin
      v = '0;
      for (int r = 0; r < 4; r++) begin
        dd[r] = '0;
        if (c >= r && c <= r + 2) begin
          v[r] = 1'b1;
          dd[r] = 16'(r * 16 + (c - r));
        end
      end
      step(0, 0, 0, v, dd[0], dd[1], dd[2], dd[3], 0, 0);
      if (c == 4) check("skew_not_done", bus.done, 0);
    end
    check("skew_done", bus.done, 1);
    for (int k = 0; k < 3; k++) begin
      for (int r = 0; r < 4; r++) begin
        rd(10'(4 * k + r));
        check("skew_rd", bus.rd_data, 32'(r * 16 + k));
      end
    end
    idle(1);
    check("rd_valid_pulse", bus.rd_valid, 0);

    // Overflow: lane0 gets three samples with len=2
    step(0, 1, 9'd2, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      v = (c < 3) ? 4'b0001 : 4'b1110;
      step(0, 0, 0, v, 16'(16'hA0 + c), 16'(16'hB0 + c), 16'(16'hC0 + c),
           16'(16'hD0 + c), 0, 0);
      if (c == 2) begin
        check("ovf_set", bus.overflow, 1);
        check("ovf_not_done", bus.done, 0);
      end
    end
    check("ovf_done", bus.done, 1);
    rd(10'd8);
    check("ovf_mem02", bus.rd_data, 16'h0002);

    // Full depth
    step(0, 1, 9'd256, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 256; c++) begin
      step(0, 0, 0, 4'hF, 16'(c), 16'(c), 16'(c), 16'(c), 0, 0);
      if (c == 254) check("full_not_done", bus.done, 0);
    end
    check("full_done", bus.done, 1);
    check("full_ovf", bus.overflow, 0);
    rd(10'd1023);
    check("full_rd1023", bus.rd_data, 255);

    // Restart mid-capture with colliding valids
    step(0, 1, 9'd5, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 2; c++)
      step(0, 0, 0, 4'hF, 16'(16'h1100 + c), 16'(16'h1100 + c), 16'(16'h1100 + c),
           16'(16'h1100 + c), 0, 0);
    step(0, 1, 9'd4, 4'hF, 16'hDEAD, 16'hDEAD, 16'hDEAD, 16'hDEAD, 0, 0);
    check("restart_busy", bus.busy, 1);
    for (int c = 0; c < 4; c++)
      step(0, 0, 0, 4'hF, 16'(16'h2200 + 4 * c), 16'(16'h2200 + 4 * c + 1),
           16'(16'h2200 + 4 * c + 2), 16'(16'h2200 + 4 * c + 3), 0, 0);
    check("restart_done", bus.done, 1);
    for (int i = 0; i < 5; i++) begin
      rd(10'(i));
      check("restart_rd", bus.rd_data, 32'(16'h2200 + i));
    end
    step(0, 1, 9'd0, 0, 0, 0, 0, 0, 0, 0);
    check("len0_done", bus.done, 1);
    check("len0_busy", bus.busy, 0);

    // Read during write of the same location
    step(0, 1, 9'd1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 4'hF, 16'hBEEF, 16'h0, 16'h0, 16'h0, 1, 10'd0);
    check("rdw_old", bus.rd_data, 16'h2200);
    rd(10'd0);
    check("rdw_new", bus.rd_data, 16'hBEEF);

    // Reset mid-capture keeps memory readable
    step(0, 1, 9'd10, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++)
      step(0, 0, 0, 4'hF, 16'(16'h3300 + c), 16'h1, 16'h2, 16'h3, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("midrst_busy", bus.busy, 0);
    rd(10'd4);
    check("midrst_rd", bus.rd_data, 16'h3301);

    // Random traffic
    for (int rnd = 0; rnd < 40; rnd++) begin
      step(0, 1, 9'($urandom_range(0, 12)), 0, 0, 0, 0, 0, 0, 0);
      for (int c = 0; c < 30; c++) begin
        a = 10'($urandom_range(0, 63));
        step($urandom_range(0, 59) == 0, $urandom_range(0, 39) == 0,
             9'($urandom_range(0, 12)), 4'($urandom), 16'($urandom), 16'($urandom),
             16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), a);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
